bram_port_arbiter: RTL and testbench

Shares one single-port BRAM between two requesters: the input loader (port 0, writes program/data image) and the core (port 1, loads/stores). This replaces the static state-based write mux with valid/ready arbitration, so the core can access BRAM while input streaming continues. Arbitration is fixed-priority with a bounded burst, which guarantees neither port starves. Read data returns to the port that issued the read.

---
 rtl/bram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-port valid/ready arbiter in front of one single-port BRAM.
// Port 0 is the input loader, port 1 the core. Fixed priority with a bounded
// burst so that neither port starves; read data is routed back to its issuer.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              excl0,
    // Port 0: input loader
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    // Port 1: core
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    // BRAM side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        Port0 = 1'b0,
        Port1 = 1'b1
    } port_e;

    port_e            favour_q, favour_d;
    logic [CNT_W-1:0] burst_q, burst_d;

    logic              grant0, grant1, accept;
    logic              fav_granted, other_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Read owner tags: stage 1 tracks the strobe cycle, stage 2 the data cycle
    logic              rd1_v_q, rd1_own_q;
    logic              rd2_v_q, rd2_own_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

    // Grant decode: excl0 locks out port 1, otherwise the favoured port wins a tie
    always_comb begin
        grant0    = p0_valid && (excl0 || !p1_valid || (favour_q == Port0));
        grant1    = !excl0 && p1_valid && !grant0;
        accept    = grant0 || grant1;
        sel_we    = grant1 ? p1_we    : p0_we;
        sel_addr  = grant1 ? p1_addr  : p0_addr;
        sel_wdata = grant1 ? p1_wdata : p0_wdata;
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Burst accounting; frozen while excl0 so exclusive mode leaves favour untouched
    always_comb begin
        favour_d    = favour_q;
        burst_d     = burst_q;
        fav_granted = (favour_q == Port0) ? grant0   : grant1;
        other_valid = (favour_q == Port0) ? p1_valid : p0_valid;
        if (!excl0) begin
            if (!other_valid) begin
                burst_d = '0;
            end else if (fav_granted) begin
                if (burst_q == CNT_W'(MAX_BURST - 1)) begin
                    favour_d = (favour_q == Port0) ? Port1 : Port0;
                    burst_d  = '0;
                end else begin
                    burst_d = burst_q + CNT_W'(1);
                end
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            favour_q <= Port0;
            burst_q  <= '0;
        end else begin
            favour_q <= favour_d;
            burst_q  <= burst_d;
        end
    end

    // Registered BRAM command: one access per accepted request, no bubbles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= accept;
            mem_we_q <= accept && sel_we;
            if (accept) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Owner tag pipeline; reset drops any read in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd1_v_q   <= 1'b0;
            rd1_own_q <= 1'b0;
            rd2_v_q   <= 1'b0;
            rd2_own_q <= 1'b0;
        end else begin
            rd1_v_q   <= accept && !sel_we;
            rd1_own_q <= grant1;
            rd2_v_q   <= rd1_v_q;
            rd2_own_q <= rd1_own_q;
        end
    end

    assign p0_rvalid = rd2_v_q && !rd2_own_q;
    assign p1_rvalid = rd2_v_q && rd2_own_q;

    // Capture returned words so each port's rdata holds between responses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            if (p0_rvalid) p0_rdata_q <= mem_rdata;
            if (p1_rvalid) p1_rdata_q <= mem_rdata;
        end
    end

    assign p0_rdata = p0_rvalid ? mem_rdata : p0_rdata_q;
    assign p1_rdata = p1_rvalid ? mem_rdata : p1_rdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small behavioural BRAM.
module tb_bram_port_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BURST = 4;

    logic              clk;
    logic              rstn;
    logic              excl0;
    logic              p0_valid, p0_ready, p0_we, p0_rvalid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_pass;
    int n_total;

    logic [DATA_W-1:0] bram [0:255];

    bram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .excl0     (excl0),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port BRAM, one cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= bram[mem_addr[9:2]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // 0 = only p0 ready, 1 = only p1 ready, 2 = neither, 3 = both
    function automatic int grant_code(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (!r0 && !r1) return 2;
        return 3;
    endfunction

    task automatic idle_inputs();
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn  = 1'b0;
        excl0 = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic write_word(input int port, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        @(negedge clk);
        if (port == 0) begin
            p0_valid = 1'b1; p0_we = 1'b1; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = 1'b1; p1_we = 1'b1; p1_addr = a; p1_wdata = d;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn  = 1'b0;
        excl0 = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en);
        else n_pass++;
        n_total++;
        if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we);
        else n_pass++;
        n_total++;
        if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
        else n_pass++;
        n_total++;
        if (mem_wdata !== '0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata);
        else n_pass++;
        n_total++;
        if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0)
            $display("FAIL reset_rvalid: got %b%b want 00", p0_rvalid, p1_rvalid);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        write_word(0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h10;
        #1;
        n_total++;
        if (grant_code(p0_ready, p1_ready) != 1)
            $display("FAIL read_grant: got code %0d want 1", grant_code(p0_ready, p1_ready));
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10)
            $display("FAIL read_strobe: got en=%b we=%b addr=%h want en=1 we=0 addr=10",
                     mem_en, mem_we, mem_addr);
        else n_pass++;
        @(negedge clk);
        p1_valid = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hDEAD_BEEF || p0_rvalid !== 1'b0)
            $display("FAIL read_resp: got p1_rvalid=%b p1_rdata=%h p0_rvalid=%b want 1 deadbeef 0",
                     p1_rvalid, p1_rdata, p0_rvalid);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (p1_rvalid !== 1'b0 || p1_rdata !== 32'hDEAD_BEEF || mem_en !== 1'b0)
            $display("FAIL read_after: got p1_rvalid=%b p1_rdata=%h mem_en=%b want 0 deadbeef 0",
                     p1_rvalid, p1_rdata, mem_en);
        else n_pass++;
    endtask

    task automatic test_excl0();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            excl0    = 1'b1;
            p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h40;
            p0_valid = 1'b1; p0_we = 1'b1;
            p0_addr  = 32'(i * 4);
            p0_wdata = 32'h100 + 32'(i);
            #1;
            n_total++;
            if (p0_ready !== 1'b1 || p1_ready !== 1'b0)
                $display("FAIL excl0_ready[%0d]: got p0=%b p1=%b want p0=1 p1=0",
                         i, p0_ready, p1_ready);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'(i * 4)
                || mem_wdata !== 32'h100 + 32'(i))
                $display("FAIL excl0_write[%0d]: got en=%b we=%b addr=%h data=%h want 1 1 %h %h",
                         i, mem_en, mem_we, mem_addr, mem_wdata, i * 4, 32'h100 + 32'(i));
            else n_pass++;
        end
        @(negedge clk);
        excl0 = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        n_total++;
        if (mem_en !== 1'b0) $display("FAIL excl0_idle: got mem_en=%b want 0", mem_en);
        else n_pass++;
    endtask

    task automatic test_burst();
        int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h100; p0_wdata = 32'(i);
            p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h200; p1_wdata = 32'(i);
            #1;
            n_total++;
            if (grant_code(p0_ready, p1_ready) != exp_seq[i])
                $display("FAIL burst_grant[%0d]: got code %0d want %0d",
                         i, grant_code(p0_ready, p1_ready), exp_seq[i]);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (mem_en !== 1'b1) $display("FAIL burst_no_bubble[%0d]: got mem_en=%b want 1", i, mem_en);
            else n_pass++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_pipelined_reads();
        int port;
        int exp_port;
        logic [DATA_W-1:0] exp_data;
        apply_reset();
        write_word(0, 32'h0, 32'h1111_1111);
        write_word(1, 32'h4, 32'h2222_2222);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) begin
                port     = k % 2;
                p0_valid = (port == 0); p0_we = 1'b0; p0_addr = 32'h0;
                p1_valid = (port == 1); p1_we = 1'b0; p1_addr = 32'h4;
                #1;
                n_total++;
                if (grant_code(p0_ready, p1_ready) != port)
                    $display("FAIL pipe_grant[%0d]: got code %0d want %0d",
                             k, grant_code(p0_ready, p1_ready), port);
                else n_pass++;
            end else begin
                idle_inputs();
            end
            @(posedge clk); #1;
            if (k >= 1 && k <= 8) begin
                exp_port = (k - 1) % 2;
                exp_data = (exp_port == 0) ? 32'h1111_1111 : 32'h2222_2222;
                n_total++;
                if (p0_rvalid !== (exp_port == 0) || p1_rvalid !== (exp_port == 1)
                    || (exp_port == 0 && p0_rdata !== exp_data)
                    || (exp_port == 1 && p1_rdata !== exp_data))
                    $display("FAIL pipe_resp[%0d]: got rv=%b%b d0=%h d1=%h want port %0d data %h",
                             k, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, exp_port, exp_data);
                else n_pass++;
            end else begin
                n_total++;
                if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0)
                    $display("FAIL pipe_quiet[%0d]: got rv=%b%b want 00", k, p0_rvalid, p1_rvalid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        int exp_seq [5] = '{0, 0, 0, 0, 1};
        apply_reset();
        // Four contended writes move favour to port 1 before the reset hits
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h300;
            p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h304;
        end
        @(negedge clk);
        idle_inputs();
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h10;
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0)
            $display("FAIL areset_pre: got mem_en=%b mem_we=%b want 1 0", mem_en, mem_we);
        else n_pass++;
        #1;
        rstn = 1'b0;
        #1;
        n_total++;
        if (mem_en !== 1'b0 || mem_addr !== '0 || p1_rvalid !== 1'b0 || p0_rvalid !== 1'b0)
            $display("FAIL areset_now: got en=%b addr=%h rv=%b%b want 0 0 00",
                     mem_en, mem_addr, p0_rvalid, p1_rvalid);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0)
                $display("FAIL areset_no_rvalid[%0d]: got rv=%b%b want 00", i, p0_rvalid, p1_rvalid);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h300;
            p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h304;
            #1;
            n_total++;
            if (grant_code(p0_ready, p1_ready) != exp_seq[i])
                $display("FAIL areset_favour[%0d]: got code %0d want %0d",
                         i, grant_code(p0_ready, p1_ready), exp_seq[i]);
            else n_pass++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_p1_then_p0();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h40 + 32'(i * 4); p1_wdata = 32'(i);
            #1;
            n_total++;
            if (grant_code(p0_ready, p1_ready) != 1)
                $display("FAIL p1_alone[%0d]: got code %0d want 1", i, grant_code(p0_ready, p1_ready));
            else n_pass++;
        end
        @(negedge clk);
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h80;
        #1;
        n_total++;
        if (grant_code(p0_ready, p1_ready) != 0)
            $display("FAIL p0_joins: got code %0d want 0", grant_code(p0_ready, p1_ready));
        else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rstn    = 1'b0;
        excl0   = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_excl0();
        test_burst();
        test_pipelined_reads();
        test_async_reset();
        test_p1_then_p0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
